// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the Hyperbus user-side arbiter.
package hyperbus_pkg;

  // One-hot controller states.
  typedef enum logic [2:0] {
    StIdle   = 3'b001,
    StIssue  = 3'b010,
    StWaitRd = 3'b100
  } state_t;

  // Command encodings carried on we_i.
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Default timing parameters.
  localparam int unsigned DEFAULT_GUARD   = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // Bits needed to hold a down-counter starting at max_val (at least one).
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hyperbus_rr_arbiter.sv
// Rotating-priority picker: search starts just after `last` and wraps.
module hyperbus_rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         gnt,
  output logic                    valid
);

  int unsigned idx;

  // First active request at or after last+1, modulo NREQ.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin scheduler sharing the Hyperbus FIFO user port among NREQ requesters.
module hyperbus_arbiter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GUARD      = DEFAULT_GUARD,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_i,
  input  logic [NREQ-1:0]            we_i,
  input  logic [NREQ*ADDR_WIDTH-1:0] adr_i,
  input  logic [NREQ*DATA_WIDTH-1:0] dat_i,
  output logic [NREQ-1:0]            gnt_o,
  output logic [NREQ-1:0]            ack_o,
  output logic [NREQ-1:0]            err_o,
  output logic [DATA_WIDTH-1:0]      dat_o,
  output logic                       fifo_rrq,
  output logic                       fifo_wrq,
  output logic [ADDR_WIDTH-1:0]      fifo_adr,
  output logic [DATA_WIDTH-1:0]      fifo_tx_dat,
  input  logic                       fifo_tx_ready,
  input  logic [DATA_WIDTH-1:0]      fifo_rx_dat,
  input  logic                       fifo_rx_valid
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned GW = cnt_width(GUARD);
  localparam int unsigned TW = cnt_width(TIMEOUT);

  state_t                state_q, state_d;
  logic [IW-1:0]         last_q, last_d, win_q, win_d;
  logic                  win_we_q, win_we_d;
  logic [GW-1:0]         guard_q, guard_d;
  logic [TW-1:0]         wd_q, wd_d;
  logic [NREQ-1:0]       gnt_q, gnt_d, ack_q, ack_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d, tx_dat_q, tx_dat_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  rrq_q, rrq_d, wrq_q, wrq_d;

  logic [NREQ-1:0]       pick_gnt;
  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;

  hyperbus_rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .req  (req_i),
    .last (last_q),
    .gnt  (pick_gnt),
    .valid(pick_valid)
  );

  // Encode the one-hot pick into an index.
  always_comb begin
    pick_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick_gnt[k]) pick_idx = IW'(k);
    end
  end

  // Next-state logic; all outputs are registered, so the ISSUE-cycle strobes
  // and the posted-write ack are loaded on the granting edge.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    win_we_d = win_we_q;
    guard_d  = (guard_q != '0) ? guard_q - 1'b1 : '0;
    wd_d     = wd_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    err_d    = '0;
    dat_d    = dat_q;
    tx_dat_d = tx_dat_q;
    adr_d    = adr_q;
    rrq_d    = 1'b0;
    wrq_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid && guard_q == '0 && fifo_tx_ready) begin
          win_d    = pick_idx;
          win_we_d = we_i[pick_idx];
          adr_d    = adr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          tx_dat_d = dat_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          gnt_d    = pick_gnt;
          wrq_d    = (we_i[pick_idx] == CMD_WRITE);
          rrq_d    = (we_i[pick_idx] == CMD_READ);
          ack_d    = (we_i[pick_idx] == CMD_WRITE) ? pick_gnt : '0;
          guard_d  = GW'(GUARD);
          wd_d     = TW'(TIMEOUT);
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (win_we_q == CMD_WRITE) begin
          gnt_d   = '0;
          last_d  = win_q;
          state_d = StIdle;
        end else begin
          state_d = StWaitRd;
        end
      end
      StWaitRd: begin
        if (fifo_rx_valid) begin
          dat_d   = fifo_rx_dat;
          ack_d   = gnt_q;
          gnt_d   = '0;
          last_d  = win_q;
          state_d = StIdle;
        end else if (TIMEOUT != 0) begin
          if (wd_q <= TW'(1)) begin
            err_d   = gnt_q;
            gnt_d   = '0;
            last_d  = win_q;
            state_d = StIdle;
          end else begin
            wd_d = wd_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= IW'(NREQ - 1);
      win_q    <= '0;
      win_we_q <= 1'b0;
      guard_q  <= '0;
      wd_q     <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      dat_q    <= '0;
      tx_dat_q <= '0;
      adr_q    <= '0;
      rrq_q    <= 1'b0;
      wrq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      win_we_q <= win_we_d;
      guard_q  <= guard_d;
      wd_q     <= wd_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      tx_dat_q <= tx_dat_d;
      adr_q    <= adr_d;
      rrq_q    <= rrq_d;
      wrq_q    <= wrq_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign dat_o       = dat_q;
  assign fifo_rrq    = rrq_q;
  assign fifo_wrq    = wrq_q;
  assign fifo_adr    = adr_q;
  assign fifo_tx_dat = tx_dat_q;

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Scenario bench for hyperbus_arbiter with a scoreboard of expected completions.
module tb_hyperbus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned G  = 4;
  localparam int unsigned T  = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [N*AW-1:0] adr = '0;
  logic [N*DW-1:0] dat = '0;
  logic [N-1:0]    gnt_o, ack_o, err_o;
  logic [DW-1:0]   dat_o;
  logic            fifo_rrq, fifo_wrq;
  logic [AW-1:0]   fifo_adr;
  logic [DW-1:0]   fifo_tx_dat;
  logic            tx_ready = 1'b1;
  logic [DW-1:0]   rx_dat = '0;
  logic            rx_valid = 1'b0;

  typedef struct {
    int          idx;
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hyperbus_arbiter #(
    .NREQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GUARD(G), .TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .adr_i(adr), .dat_i(dat),
    .gnt_o(gnt_o), .ack_o(ack_o), .err_o(err_o), .dat_o(dat_o),
    .fifo_rrq(fifo_rrq), .fifo_wrq(fifo_wrq), .fifo_adr(fifo_adr),
    .fifo_tx_dat(fifo_tx_dat), .fifo_tx_ready(tx_ready),
    .fifo_rx_dat(rx_dat), .fifo_rx_valid(rx_valid)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; we = '0; rx_valid = 1'b0; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for any ack/err, checking the current sample first.
  task automatic wait_resp(input int budget, output bit seen);
    int cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      if ((ack_o | err_o) != '0) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (gnt_o !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
    checks++; if (ack_o !== 4'b0 || err_o !== 4'b0) begin errors++;
      $display("FAIL reset_ack_err: got ack %b err %b want 0", ack_o, err_o); end
    checks++; if (fifo_rrq !== 1'b0 || fifo_wrq !== 1'b0) begin errors++;
      $display("FAIL reset_strobes: got rrq %b wrq %b want 0", fifo_rrq, fifo_wrq); end
    checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", dat_o); end
    checks++; if (fifo_adr !== 32'h0 || fifo_tx_dat !== 32'h0) begin errors++;
      $display("FAIL reset_fifo_bus: got adr %h tx %h want 0", fifo_adr, fifo_tx_dat); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (gnt_o !== 4'b0) begin errors++; $display("FAIL idle_no_grant: got %b want 0000", gnt_o); end
  endtask

  task automatic test_read_return();
    exp_t e;
    bit   seen;
    bit   gnt_bad = 1'b0;
    do_reset();
    adr[2*AW +: AW] = 32'h0000_0100;
    we[2] = 1'b0; req[2] = 1'b1;
    @(negedge clk);
    checks++; if (gnt_o !== 4'b0100) begin errors++; $display("FAIL rd_gnt: got %b want 0100", gnt_o); end
    checks++; if (fifo_rrq !== 1'b1 || fifo_wrq !== 1'b0) begin errors++;
      $display("FAIL rd_strobe: got rrq %b wrq %b want 1 0", fifo_rrq, fifo_wrq); end
    checks++; if (fifo_adr !== 32'h100) begin errors++; $display("FAIL rd_adr: got %h want 00000100", fifo_adr); end
    sb.push_back('{idx: 2, is_err: 1'b0, data: 32'hDEAD_BEEF});
    repeat (10) begin
      @(negedge clk);
      if (gnt_o !== 4'b0100 || (ack_o | err_o) !== 4'b0) gnt_bad = 1'b1;
    end
    checks++; if (gnt_bad) begin errors++; $display("FAIL rd_gnt_hold: got gnt %b want 0100 held", gnt_o); end
    rx_dat = 32'hDEAD_BEEF; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_resp(5, seen);
    e = sb.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL rd_ack_timeout: got no ack want ack"); end
    checks++; if (ack_o !== (4'b0001 << e.idx) || err_o !== 4'b0) begin errors++;
      $display("FAIL rd_ack: got ack %b err %b want ack %b", ack_o, err_o, 4'b0001 << e.idx); end
    checks++; if (dat_o !== e.data) begin errors++; $display("FAIL rd_dat: got %h want %h", dat_o, e.data); end
    req[2] = 1'b0;
    @(negedge clk);
    checks++; if (dat_o !== 32'hDEAD_BEEF || gnt_o !== 4'b0) begin errors++;
      $display("FAIL rd_after: got dat %h gnt %b want deadbeef 0000", dat_o, gnt_o); end
  endtask

  task automatic test_stray_backpressure();
    exp_t e;
    bit   busy = 1'b0;
    int   cyc = 0;
    tx_ready = 1'b0;
    we[0] = 1'b1; req[0] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (fifo_rrq || fifo_wrq || gnt_o != 4'b0) busy = 1'b1;
    end
    checks++; if (busy) begin errors++; $display("FAIL bp_no_strobe: got activity want none"); end
    rx_dat = 32'h1234_5678; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    checks++; if (dat_o !== 32'hDEAD_BEEF || ack_o !== 4'b0) begin errors++;
      $display("FAIL stray_rx: got dat %h ack %b want deadbeef 0000", dat_o, ack_o); end
    tx_ready = 1'b1;
    sb.push_back('{idx: 0, is_err: 1'b0, data: 32'h0});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (gnt_o !== 4'b0001 || fifo_wrq !== 1'b1 || ack_o !== (4'b0001 << e.idx)) begin errors++;
      $display("FAIL bp_release: got gnt %b wrq %b ack %b want 0001 1 0001", gnt_o, fifo_wrq, ack_o); end
    // Next request must still wait out the guard even if TX frees up early.
    req[0] = 1'b0; we[1] = 1'b1; req[1] = 1'b1; tx_ready = 1'b0;
    while (cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) tx_ready = 1'b1;
      if (fifo_wrq) break;
    end
    checks++; if (cyc != int'(G) + 1 || ack_o !== 4'b0010) begin errors++;
      $display("FAIL guard_spacing: got %0d cycles ack %b want %0d 0010", cyc, ack_o, G + 1); end
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_timeout();
    exp_t        e;
    int          cyc = 0;
    logic [31:0] dat_before;
    do_reset();
    we[1] = 1'b0; req[1] = 1'b1;
    we[3] = 1'b1; req[3] = 1'b1;
    @(negedge clk);
    checks++; if (gnt_o !== 4'b0010 || fifo_rrq !== 1'b1) begin errors++;
      $display("FAIL to_gnt: got gnt %b rrq %b want 0010 1", gnt_o, fifo_rrq); end
    dat_before = dat_o;
    sb.push_back('{idx: 1, is_err: 1'b1, data: dat_before});
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if ((ack_o | err_o) != 4'b0) break;
    end
    e = sb.pop_front();
    checks++; if (cyc != int'(T) + 1) begin errors++;
      $display("FAIL to_latency: got %0d cycles want %0d", cyc, T + 1); end
    checks++; if (err_o !== (4'b0001 << e.idx) || ack_o !== 4'b0 || !e.is_err) begin errors++;
      $display("FAIL to_err: got err %b ack %b want err %b", err_o, ack_o, 4'b0001 << e.idx); end
    checks++; if (dat_o !== e.data) begin errors++; $display("FAIL to_dat: got %h want %h", dat_o, e.data); end
    req[1] = 1'b0;
    @(negedge clk);
    checks++; if (gnt_o !== 4'b1000 || ack_o !== 4'b1000) begin errors++;
      $display("FAIL to_next: got gnt %b ack %b want 1000 1000", gnt_o, ack_o); end
    req[3] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fairness();
    exp_t e;
    int   cyc = 0;
    int   last_cyc = -1;
    int   grants = 0;
    do_reset();
    for (int i = 0; i < 100; i++) sb.push_back('{idx: i % 4, is_err: 1'b0, data: 32'h0});
    we = 4'hF; req = 4'hF;
    while (grants < 100 && cyc < 100 * (int'(G) + 1) + 50) begin
      @(negedge clk);
      cyc++;
      if (ack_o != 4'b0) begin
        e = sb.pop_front();
        checks++; if (ack_o !== (4'b0001 << e.idx)) begin errors++;
          $display("FAIL rr_order: grant %0d got ack %b want %b", grants, ack_o, 4'b0001 << e.idx); end
        checks++; if (fifo_wrq !== 1'b1 || fifo_adr !== adr[e.idx*AW +: AW]
                      || fifo_tx_dat !== dat[e.idx*DW +: DW]) begin errors++;
          $display("FAIL rr_cmd: grant %0d got wrq %b adr %h tx %h want 1 %h %h", grants, fifo_wrq,
                   fifo_adr, fifo_tx_dat, adr[e.idx*AW +: AW], dat[e.idx*DW +: DW]); end
        if (last_cyc >= 0) begin
          checks++; if (cyc - last_cyc != int'(G) + 1) begin errors++;
            $display("FAIL rr_spacing: grant %0d got %0d want %0d", grants, cyc - last_cyc, G + 1); end
        end
        last_cyc = cyc;
        grants++;
      end
    end
    checks++; if (grants != 100) begin errors++; $display("FAIL rr_count: got %0d want 100", grants); end
    req = '0;
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    bit bad = 1'b0;
    do_reset();
    we[0] = 1'b0; req[0] = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (gnt_o !== 4'b0001 || fifo_adr !== adr[AW-1:0]) begin errors++;
      $display("FAIL mid_pre: got gnt %b adr %h want 0001 %h", gnt_o, fifo_adr, adr[AW-1:0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (gnt_o !== 4'b0 || ack_o !== 4'b0 || err_o !== 4'b0 || fifo_rrq !== 1'b0
                  || fifo_wrq !== 1'b0 || fifo_adr !== 32'h0 || dat_o !== 32'h0) begin errors++;
      $display("FAIL mid_reset: got gnt %b adr %h dat %h want all 0", gnt_o, fifo_adr, dat_o); end
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rx_dat = 32'hCAFE_F00D; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (6) begin
      if (ack_o != 4'b0 || err_o != 4'b0 || gnt_o != 4'b0 || dat_o != 32'h0) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad) begin errors++;
      $display("FAIL mid_late_rx: got ack %b dat %h want 0000 0", ack_o, dat_o); end
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      adr[i*AW +: AW] = 32'h0000_1000 + 32'(i * 16);
      dat[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    end
    test_reset();
    test_read_return();
    test_stray_backpressure();
    test_read_timeout();
    test_fairness();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
